// File: rtl/cache_pkg.sv
// Shared constants and encodings for the split I/D cache memory path.
// Holds line geometry, arbiter state encoding and requester IDs.
package cache_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  function automatic arb_state_e grant_state(input logic who);
    return (who == REQ_I) ? GNT_I : GNT_D;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker: on a tie the requester that was
// not served last wins; a lone requester always wins.
module rr_pick2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = REQ_I;
    if (req[REQ_I] && req[REQ_D]) begin
      winner = ~last;
    end else if (req[REQ_D]) begin
      winner = REQ_D;
    end else begin
      winner = REQ_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache,
// round-robin, holding the grant across a write-back and its refill.
module mem_arbiter #(
  parameter int unsigned ADDR_W = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W = cache_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  import cache_pkg::*;

  arb_state_e state;
  logic       last_grant;
  logic       lock;

  logic       pick_winner;
  logic       pick_any;
  logic       owner;
  logic       sel_read;
  logic       sel_write;
  logic       sel_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req    ({d_read | d_write, i_read | i_write}),
    .last   (last_grant),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign owner = (state == GNT_D) ? REQ_D : REQ_I;

  always_comb begin
    if (owner == REQ_D) begin
      sel_read  = d_read;
      sel_write = d_write;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else begin
      sel_read  = i_read;
      sel_write = i_write;
      sel_addr  = i_addr;
      sel_wdata = i_wdata;
    end
    sel_req = sel_read | sel_write;
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Outputs follow the registered state directly, so an async reset drops
  // the strobes immediately without waiting for a clock edge.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    if (state == GNT_I || state == GNT_D) begin
      mem_write = sel_write;
      mem_read  = sel_read & ~sel_write;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      if (owner == REQ_I) begin
        i_ready = mem_ready;
      end else begin
        d_ready = mem_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_I;
      lock       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state <= grant_state(pick_winner);
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            last_grant <= owner;
            // A write completing under an existing lock would start a second
            // miss sequence; release instead so the other cache is not starved.
            if (sel_write && !lock) begin
              lock <= 1'b1;
            end else begin
              lock  <= 1'b0;
              state <= IDLE;
            end
          end else if (!sel_req) begin
            lock  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          lock  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: arbitration order, lock
// across write-back + refill, idle ready filtering and async reset.
module tb_mem_arbiter;
  import cache_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic              i_ready, d_ready, mem_read, mem_write, mem_ready;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_read    = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read    = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [DATA_W-1:0] pat_a5;

  initial begin
    n_checks = 0;
    n_errors = 0;
    pat_a5   = {16{8'hA5}};

    // Reset state
    do_reset();
    check("rst_state", dut.state, IDLE);
    check("rst_last", dut.last_grant, REQ_I);
    check("rst_lock", dut.lock, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_ready", {i_ready, d_ready}, 2'b00);

    // Single I read with 1-cycle arbitration latency
    i_read = 1'b1; i_addr = 28'h0000010;
    #1 check("i_lat_idle", mem_read, 1'b0);
    tick();
    check("i_gnt_read", mem_read, 1'b1);
    check("i_gnt_addr", mem_addr, 28'h0000010);
    mem_rdata = pat_a5; mem_ready = 1'b1;
    #1;
    check("i_ready", i_ready, 1'b1);
    check("i_d_ready", d_ready, 1'b0);
    check("i_rdata", i_rdata, pat_a5);
    check("d_rdata_bcast", d_rdata, pat_a5);
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    #1;
    check("i_done_state", dut.state, IDLE);
    check("i_done_read", mem_read, 1'b0);

    // Tie after reset: D first, then I after one IDLE cycle
    do_reset();
    i_read = 1'b1; i_addr = 28'h0000020;
    d_read = 1'b1; d_addr = 28'h0000030;
    tick();
    check("tie1_state", dut.state, GNT_D);
    check("tie1_addr", mem_addr, 28'h0000030);
    mem_ready = 1'b1;
    #1 check("tie1_ready", {i_ready, d_ready}, 2'b01);
    tick();
    mem_ready = 1'b0; d_read = 1'b0;
    #1;
    check("tie1_gap", dut.state, IDLE);
    check("tie1_gap_read", mem_read, 1'b0);
    tick();
    check("tie1_i_state", dut.state, GNT_I);
    check("tie1_i_addr", mem_addr, 28'h0000020);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    // D alone so last_grant becomes D
    d_read = 1'b1; d_addr = 28'h0000031;
    tick();
    check("d_alone", dut.state, GNT_D);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; d_read = 1'b0;
    check("last_is_d", dut.last_grant, REQ_D);
    i_read = 1'b1; d_read = 1'b1;
    tick();
    check("tie2_state", dut.state, GNT_I);
    check("tie2_addr", mem_addr, 28'h0000020);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; i_read = 1'b0; d_read = 1'b0;
    tick();

    // D write-back + refill while I waits
    d_write = 1'b1; d_addr = 28'h0000123; d_wdata = 128'h1234;
    tick();
    i_read = 1'b1; i_addr = 28'h0000040;
    #1;
    check("wb_state", dut.state, GNT_D);
    check("wb_rw", {mem_write, mem_read}, 2'b10);
    check("wb_addr", mem_addr, 28'h0000123);
    check("wb_wdata", mem_wdata, 128'h1234);
    mem_ready = 1'b1;
    #1 check("wb_ready", {i_ready, d_ready}, 2'b01);
    tick();
    mem_ready = 1'b0; d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000456;
    #1;
    check("rf_state", dut.state, GNT_D);
    check("rf_lock", dut.lock, 1'b1);
    check("rf_rw", {mem_write, mem_read}, 2'b01);
    check("rf_addr", mem_addr, 28'h0000456);
    tick();
    check("rf_hold", dut.state, GNT_D);
    check("rf_i_wait", i_ready, 1'b0);
    mem_ready = 1'b1;
    #1 check("rf_ready", {i_ready, d_ready}, 2'b01);
    tick();
    mem_ready = 1'b0; d_read = 1'b0;
    #1;
    check("rf_gap", dut.state, IDLE);
    check("rf_unlock", dut.lock, 1'b0);
    tick();
    check("rf_i_gnt", dut.state, GNT_I);
    check("rf_i_addr", mem_addr, 28'h0000040);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    tick();

    // mem_ready while IDLE is ignored
    mem_ready = 1'b1;
    #1 check("idle_ready", {i_ready, d_ready}, 2'b00);
    tick();
    mem_ready = 1'b0;
    check("idle_stay", dut.state, IDLE);

    // Simultaneous read+write forwards write only; lock released on idle request
    i_read = 1'b1; i_write = 1'b1; i_addr = 28'h0000077; i_wdata = 128'hBEEF;
    tick();
    check("rw_both", {mem_write, mem_read}, 2'b10);
    check("rw_wdata", mem_wdata, 128'hBEEF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; i_read = 1'b0; i_write = 1'b0;
    check("rw_locked", dut.state, GNT_I);
    tick();
    check("rw_release", dut.state, IDLE);

    // Protocol violation: request dropped before mem_ready
    d_read = 1'b1; d_addr = 28'h0000099;
    tick();
    check("viol_gnt", dut.state, GNT_D);
    d_read = 1'b0;
    tick();
    check("viol_idle", dut.state, IDLE);
    check("viol_ready", {i_ready, d_ready}, 2'b00);

    // Async reset mid GNT_D
    d_read = 1'b1; d_addr = 28'h0000555;
    tick();
    check("ar_read", mem_read, 1'b1);
    #2 rst_n = 1'b0; d_read = 1'b0;
    #1;
    check("ar_drop", mem_read, 1'b0);
    check("ar_state", dut.state, IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    mem_ready = 1'b1;
    #1 check("ar_stale", d_ready, 1'b0);
    tick();
    mem_ready = 1'b0; d_read = 1'b1;
    #1 check("ar_fresh_idle", mem_read, 1'b0);
    tick();
    check("ar_fresh_read", mem_read, 1'b1);
    check("ar_fresh_addr", mem_addr, 28'h0000555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
